rf_write_sched: RTL

RF_WRITE_SCHED -- requirements
Module: rf_write_sched

---
 rtl/rf_write_sched_pkg.sv | 20 ++
 rtl/rf_write_sched_if.sv | 21 ++
 rtl/rf_write_sched_rr_arb2.sv | 10 +
 rtl/rf_write_sched.sv | 106 ++++++++++
 4 files changed

// File: rtl/rf_write_sched_pkg.sv
// Shared types for the register-file write scheduler: FSM states and the
// write-request payload carried by each requester.
package rf_write_sched_pkg;

    localparam int ADDR_MAX = 16;   // widest supported RAW
    localparam int DATA_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                acc;
        logic [ADDR_MAX-1:0] addr;
        logic [DATA_W-1:0]   data;
    } req_t;

endpackage

// File: rtl/rf_write_sched_if.sv
// Requester/clear handshake bundle; master drives requests, slave is the scheduler.
interface rf_write_sched_if #(parameter int RAW = 4);
    logic           a_valid, a_ready, a_acc;
    logic [RAW-1:0] a_addr;
    logic [7:0]     a_data;
    logic           b_valid, b_ready, b_acc;
    logic [RAW-1:0] b_addr;
    logic [7:0]     b_data;
    logic           clr_start, clr_busy, clr_done;

    modport master (
        output a_valid, a_acc, a_addr, a_data,
        output b_valid, b_acc, b_addr, b_data, clr_start,
        input  a_ready, b_ready, clr_busy, clr_done
    );
    modport slave (
        input  a_valid, a_acc, a_addr, a_data,
        input  b_valid, b_acc, b_addr, b_data, clr_start,
        output a_ready, b_ready, clr_busy, clr_done
    );
endinterface

// File: rtl/rf_write_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone valid wins; on a tie the side that
// was not served last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] & (~valid[1] | last);
    assign grant[1] = valid[1] & (~valid[0] | ~last);
endmodule

// File: rtl/rf_write_sched.sv
// Register-file write scheduler: arbitrates two write requesters onto one
// registered write port and runs a zero-fill sweep of the whole file.
module rf_write_sched
    import rf_write_sched_pkg::*;
#(
    parameter int RAW = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic           a_acc,
    input  logic [RAW-1:0] a_addr,
    input  logic [7:0]     a_data,
    input  logic           b_valid,
    output logic           b_ready,
    input  logic           b_acc,
    input  logic [RAW-1:0] b_addr,
    input  logic [7:0]     b_data,
    input  logic           clr_start,
    output logic           clr_busy,
    output logic           clr_done,
    output logic           acc_wen,
    output logic           reg_wen,
    output logic [RAW-1:0] write_addr_o,
    output logic [7:0]     write_data_o,
    output logic           last_grant_o
);
    state_t         state;
    logic [RAW-1:0] cnt;
    logic [1:0]     grant;
    logic           idle_ok;
    req_t           req_a, req_b, sel;

    assign req_a = '{acc: a_acc, addr: ADDR_MAX'(a_addr), data: a_data};
    assign req_b = '{acc: b_acc, addr: ADDR_MAX'(b_addr), data: b_data};

    rr_arb2 u_arb (
        .valid ({b_valid, a_valid}),
        .last  (last_grant_o),
        .grant (grant)
    );

    // clr_start pre-empts arbitration in the same cycle it is seen
    assign idle_ok = (state == IDLE) && !clr_start;
    assign a_ready = idle_ok & grant[0];
    assign b_ready = idle_ok & grant[1];
    assign sel     = grant[1] ? req_b : req_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant_o <= 1'b1;
            acc_wen      <= 1'b0;
            reg_wen      <= 1'b0;
            write_addr_o <= '0;
            write_data_o <= '0;
            clr_busy     <= 1'b0;
            clr_done     <= 1'b0;
        end else begin
            acc_wen      <= 1'b0;
            reg_wen      <= 1'b0;
            write_addr_o <= '0;
            write_data_o <= '0;
            clr_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        // first zero write is issued on the entry edge
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                        cnt      <= '0;
                        reg_wen  <= 1'b1;
                    end else if (a_ready || b_ready) begin
                        last_grant_o <= b_ready;
                        acc_wen      <= sel.acc;
                        reg_wen      <= ~sel.acc;
                        write_addr_o <= sel.acc ? '0 : RAW'(sel.addr);
                        write_data_o <= sel.data;
                    end
                end
                CLEAR: begin
                    // cnt mirrors the address currently on the write port
                    if (cnt == '1) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        reg_wen      <= 1'b1;
                        write_addr_o <= cnt + 1'b1;
                        cnt          <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
